// File: rtl/clkdiv_pkg.sv
// clkdiv_pkg
// Shared definitions for the programmable clock divider: parameter defaults,
// the controller state encoding and a small state-decode helper.
// No ports (package).
package clkdiv_pkg;

  // Default counter / half-period width and reset half-period-1.
  localparam int CW_DEFAULT       = 8;
  localparam int DEF_HALF_DEFAULT = 3;

  // Controller states, kept as plain 2-bit constants so older code that
  // compares against raw encodings keeps working.
  //   ST_IDLE : div_clk held low, counter cleared
  //   ST_RUN  : dividing, no ratio waiting
  //   ST_PEND : dividing, a new ratio waits in pend_half for the next boundary
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_PEND = 2'd2;

  // The divider runs in every state except IDLE.
  function automatic logic state_running(input logic [1:0] st);
    return (st != ST_IDLE);
  endfunction

endpackage

// File: rtl/clkdiv_if.sv
// clkdiv_if
// Bundles the run request, the valid/ready ratio handshake and the divider
// outputs between the config logic (master) and clkdiv_ctrl (slave).
// Parameter:
//   CW          half-period width
// Signals:
//   en          level run request                    (master -> slave)
//   cfg_valid   new-ratio request                    (master -> slave)
//   cfg_half    requested half-period-1              (master -> slave)
//   cfg_ready   controller can accept a ratio        (slave -> master)
//   div_clk     divided clock                        (slave -> master)
//   rise_tick   first cycle of a high phase          (slave -> master)
//   fall_tick   first cycle of a low phase           (slave -> master)
//   active_half ratio currently in use               (slave -> master)
//   busy        divider not idle                     (slave -> master)
interface clkdiv_if #(
  parameter int CW = 8
);
  logic          en;
  logic          cfg_valid;
  logic [CW-1:0] cfg_half;
  logic          cfg_ready;
  logic          div_clk;
  logic          rise_tick;
  logic          fall_tick;
  logic [CW-1:0] active_half;
  logic          busy;

  modport master (
    output en, cfg_valid, cfg_half,
    input  cfg_ready, div_clk, rise_tick, fall_tick, active_half, busy
  );

  modport slave (
    input  en, cfg_valid, cfg_half,
    output cfg_ready, div_clk, rise_tick, fall_tick, active_half, busy
  );

endinterface

// File: rtl/clkdiv_core.sv
// clkdiv_core
// Half-period counter, div_clk toggle flop and edge tick generation.
// The period is a low phase of half+1 cycles followed by a high phase of
// half+1 cycles.
// Ports:
//   clk, rst     system clock, asynchronous active-high reset
//   run          divide while high; when low the counter and div_clk are held at 0
//   half         half-period-1 in use
//   div_clk      registered divided clock
//   at_boundary  this edge ends a high phase (falling toggle while running)
//   rise_tick    registered pulse in the first cycle div_clk is 1
//   fall_tick    registered pulse in the first cycle div_clk is 0 after a high phase
module clkdiv_core #(
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          run,
  input  logic [CW-1:0] half,
  output logic          div_clk,
  output logic          at_boundary,
  output logic          rise_tick,
  output logic          fall_tick
);

  logic [CW-1:0] count;
  logic          at_terminal;

  // half only changes while the counter is 0 (in IDLE or on the boundary
  // edge itself), so count can never run past it.
  assign at_terminal = (count == half);
  assign at_boundary = run && at_terminal && div_clk;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count     <= '0;
      div_clk   <= 1'b0;
      rise_tick <= 1'b0;
      fall_tick <= 1'b0;
    end else begin
      rise_tick <= 1'b0;
      fall_tick <= 1'b0;
      if (!run) begin
        count   <= '0;
        div_clk <= 1'b0;
      end else if (at_terminal) begin
        // Ticks are registered alongside the toggle so they line up with the
        // first cycle of the new phase.
        count     <= '0;
        div_clk   <= ~div_clk;
        rise_tick <= ~div_clk;
        fall_tick <= div_clk;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/clkdiv_ctrl.sv
// clkdiv_ctrl
// Run-time programmable clock-divider controller. Accepts new divide ratios
// over a valid/ready handshake and applies ratio changes and stop requests
// only at the falling boundary, so div_clk never has a runt phase.
// Parameters:
//   CW        counter / half-period width
//   DEF_HALF  half-period-1 loaded at reset
// Ports:
//   clk, rst  system clock, asynchronous active-high reset
//   bus       clkdiv_if slave: en, cfg_valid, cfg_half in;
//             cfg_ready, div_clk, rise_tick, fall_tick, active_half, busy out
module clkdiv_ctrl
  import clkdiv_pkg::*;
#(
  parameter int CW       = CW_DEFAULT,
  parameter int DEF_HALF = DEF_HALF_DEFAULT
) (
  input  logic     clk,
  input  logic     rst,
  clkdiv_if.slave  bus
);

  localparam logic [CW-1:0] DEF_HALF_W = CW'(DEF_HALF);

  logic [1:0]    state;
  logic [CW-1:0] active_half;
  logic [CW-1:0] pend_half;
  logic          accept;
  logic          run;
  logic          at_boundary;
  logic          div_clk;
  logic          rise_tick;
  logic          fall_tick;

  assign run    = state_running(state);
  assign accept = bus.cfg_valid && (state != ST_PEND);

  clkdiv_core #(
    .CW (CW)
  ) u_core (
    .clk         (clk),
    .rst         (rst),
    .run         (run),
    .half        (active_half),
    .div_clk     (div_clk),
    .at_boundary (at_boundary),
    .rise_tick   (rise_tick),
    .fall_tick   (fall_tick)
  );

  // en is only looked at in IDLE and on boundary edges, so a short drop of
  // en inside a period does not stop the divider.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      active_half <= DEF_HALF_W;
      pend_half   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            active_half <= bus.cfg_half;
          end
          if (bus.en) begin
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (at_boundary && !bus.en) begin
            // Stopping: a ratio arriving on this same edge is simply kept
            // for the next start, since no period is running any more.
            state <= ST_IDLE;
            if (accept) begin
              active_half <= bus.cfg_half;
            end
          end else if (accept) begin
            // Also covers an accept on a boundary edge: it waits one more
            // full period rather than changing the ratio mid-edge.
            pend_half <= bus.cfg_half;
            state     <= ST_PEND;
          end
        end
        ST_PEND: begin
          if (at_boundary) begin
            active_half <= pend_half;
            state       <= bus.en ? ST_RUN : ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.cfg_ready   = (state != ST_PEND);
  assign bus.busy        = run;
  assign bus.div_clk     = div_clk;
  assign bus.rise_tick   = rise_tick;
  assign bus.fall_tick   = fall_tick;
  assign bus.active_half = active_half;

endmodule

// File: tb/tb_clkdiv_ctrl.sv
// tb_clkdiv_ctrl
// Directed bench for clkdiv_ctrl: reset values, default divide-by-8,
// ratio change in RUN, stop at a high phase, divide-by-2, boundary-coincident
// accept and reset while a ratio is pending.
// Inputs are driven and outputs sampled on the falling edge of clk.
module tb_clkdiv_ctrl;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  int   n;

  clkdiv_if #(.CW(8)) bus ();

  clkdiv_ctrl #(
    .CW       (8),
    .DEF_HALF (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive the master side of the handshake.
  task automatic applyStimulus(input logic en, input logic valid, input logic [7:0] half);
    bus.en        = en;
    bus.cfg_valid = valid;
    bus.cfg_half  = half;
  endtask

  // One comparison against a hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int cycles);
    repeat (cycles) @(negedge clk);
  endtask

  // Cycles until the next rise_tick, bounded.
  task automatic waitRise(output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (!bus.rise_tick && cycles < 100);
  endtask

  // Cycles until the next fall_tick, bounded.
  task automatic waitFall(output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (!bus.fall_tick && cycles < 100);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    applyStimulus(1'b0, 1'b0, 8'd0);
    step(2);

    // Reset values
    checkOutput("rst_div_clk", bus.div_clk, 0);
    checkOutput("rst_rise", bus.rise_tick, 0);
    checkOutput("rst_fall", bus.fall_tick, 0);
    checkOutput("rst_active_half", bus.active_half, 3);
    checkOutput("rst_busy", bus.busy, 0);
    checkOutput("rst_cfg_ready", bus.cfg_ready, 1);

    // Default divide-by-8
    rst = 1'b0;
    applyStimulus(1'b1, 1'b0, 8'd0);
    step(1);
    checkOutput("run_busy", bus.busy, 1);
    checkOutput("run_div_low", bus.div_clk, 0);
    step(3);
    checkOutput("first_low_end", bus.div_clk, 0);
    step(1);
    checkOutput("first_rise_div", bus.div_clk, 1);
    checkOutput("first_rise_tick", bus.rise_tick, 1);
    waitFall(n);
    checkOutput("high_len_8", n, 4);
    checkOutput("fall_tick_8", bus.fall_tick, 1);
    waitRise(n);
    checkOutput("low_len_8", n, 4);
    checkOutput("active_half_3", bus.active_half, 3);

    // Ratio 1 accepted mid-low-phase
    waitFall(n);
    checkOutput("pre_change_high", n, 4);
    step(1);
    applyStimulus(1'b1, 1'b1, 8'd1);
    checkOutput("ready_before_accept", bus.cfg_ready, 1);
    step(1);
    applyStimulus(1'b1, 1'b0, 8'd0);
    checkOutput("ready_pend", bus.cfg_ready, 0);
    checkOutput("half_not_yet", bus.active_half, 3);
    waitRise(n);
    checkOutput("cur_low_kept", n, 2);
    step(3);
    checkOutput("cur_high_kept", bus.div_clk, 1);
    checkOutput("ready_until_bnd", bus.cfg_ready, 0);
    step(1);
    checkOutput("bnd_fall_tick", bus.fall_tick, 1);
    checkOutput("ready_after_bnd", bus.cfg_ready, 1);
    checkOutput("active_half_1", bus.active_half, 1);
    waitRise(n);
    checkOutput("new_low_len", n, 2);
    waitRise(n);
    checkOutput("period_4", n, 4);

    // en dropped at the start of a high phase
    applyStimulus(1'b0, 1'b0, 8'd0);
    step(1);
    checkOutput("stop_high_held", bus.div_clk, 1);
    checkOutput("stop_busy_held", bus.busy, 1);
    step(1);
    checkOutput("stop_div_low", bus.div_clk, 0);
    checkOutput("stop_fall_tick", bus.fall_tick, 1);
    checkOutput("stop_busy", bus.busy, 0);
    step(1);
    checkOutput("stop_fall_once", bus.fall_tick, 0);
    step(3);
    checkOutput("idle_div_low", bus.div_clk, 0);

    // Divide-by-2 loaded in IDLE
    applyStimulus(1'b0, 1'b1, 8'd0);
    checkOutput("idle_ready", bus.cfg_ready, 1);
    step(1);
    applyStimulus(1'b0, 1'b0, 8'd0);
    checkOutput("idle_half_0", bus.active_half, 0);
    checkOutput("idle_still", bus.busy, 0);
    applyStimulus(1'b1, 1'b0, 8'd0);
    step(1);
    checkOutput("div2_start_low", bus.div_clk, 0);
    step(1);
    checkOutput("div2_rise", bus.rise_tick, 1);
    checkOutput("div2_high", bus.div_clk, 1);
    step(1);
    checkOutput("div2_fall", bus.fall_tick, 1);
    checkOutput("div2_low", bus.div_clk, 0);
    step(1);
    checkOutput("div2_rise2", bus.rise_tick, 1);
    applyStimulus(1'b0, 1'b0, 8'd0);
    step(1);
    checkOutput("div2_stop", bus.busy, 0);

    // Accept coincident with the boundary edge
    applyStimulus(1'b0, 1'b1, 8'd3);
    step(1);
    applyStimulus(1'b1, 1'b0, 8'd0);
    checkOutput("reload_half_3", bus.active_half, 3);
    step(8);
    checkOutput("coinc_last_high", bus.div_clk, 1);
    checkOutput("coinc_ready", bus.cfg_ready, 1);
    applyStimulus(1'b1, 1'b1, 8'd5);
    step(1);
    applyStimulus(1'b1, 1'b0, 8'd0);
    checkOutput("coinc_fall", bus.fall_tick, 1);
    checkOutput("coinc_not_applied", bus.active_half, 3);
    checkOutput("coinc_pend", bus.cfg_ready, 0);
    waitFall(n);
    checkOutput("coinc_period_8", n, 8);
    checkOutput("active_half_5", bus.active_half, 5);
    checkOutput("coinc_ready_back", bus.cfg_ready, 1);
    waitRise(n);
    checkOutput("low_len_12", n, 6);
    waitRise(n);
    checkOutput("period_12", n, 12);

    // Reset while a ratio is pending
    applyStimulus(1'b1, 1'b1, 8'd7);
    step(1);
    applyStimulus(1'b1, 1'b0, 8'd0);
    checkOutput("pend_before_rst", bus.cfg_ready, 0);
    checkOutput("high_before_rst", bus.div_clk, 1);
    rst = 1'b1;
    #1;
    checkOutput("async_div_clk", bus.div_clk, 0);
    checkOutput("async_busy", bus.busy, 0);
    checkOutput("async_half", bus.active_half, 3);
    checkOutput("async_ready", bus.cfg_ready, 1);
    step(2);
    rst = 1'b0;
    step(1);
    checkOutput("post_rst_busy", bus.busy, 1);
    waitFall(n);
    checkOutput("post_rst_period", n, 8);
    checkOutput("pend_discarded", bus.active_half, 3);
    waitRise(n);
    checkOutput("post_rst_low", n, 4);

    applyStimulus(1'b0, 1'b0, 8'd0);
    step(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/clkdiv_ctrl.md
# clkdiv_ctrl

Run-time programmable clock-divider controller. It generates a divided clock `div_clk` of period 2·(half+1) `clk` cycles and accepts new divide ratios over a valid/ready handshake. New ratios and stop requests take effect only at a period boundary, so `div_clk` never produces a runt or glitched phase. It sits between the register/config logic and any consumer of a slow strobe or divided clock.

## Interface
Parameters:
- `CW`, 8: counter and half-period width; legal half values 0..2^CW−1.
- `DEF_HALF`, 3: half-period−1 loaded at reset (default divide-by-8).

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset; clock `clk`; reset `rst`, asynchronous, active-high.
- `en`  in  1  level run request.
- `cfg_valid`  in  1  new-ratio request.
- `cfg_half`  in  CW  requested half-period−1.
- `cfg_ready`  out  1  controller can accept a ratio this cycle.
- `div_clk`  out  1  divided clock, registered.
- `rise_tick`  out  1  one-cycle pulse, high in the first cycle `div_clk`==1.
- `fall_tick`  out  1  one-cycle pulse, high in the first cycle `div_clk`==0 after a high phase.
- `active_half`  out  CW  ratio currently in use.
- `busy`  out  1  state != IDLE.

## Operation
- States:
  - IDLE: `div_clk` held 0, count 0.
  - RUN: dividing, no pending ratio.
  - PEND: dividing, ratio held in `pend_half`.
- Counter rule, RUN and PEND, every edge:
  - if count==active_half: count<=0 and toggle `div_clk`.
  - else count<=count+1.
  - Period = low phase of half+1 cycles, then high phase of half+1 cycles.
- Boundary: the edge where count==active_half and `div_clk`==1, i.e. the falling toggle.
- Transitions:
  - IDLE→RUN on `en`==1; count<=0.
  - RUN→PEND on a ratio accepted.
  - RUN/PEND at a boundary:
    - apply `pend_half` to `active_half` if in PEND.
    - go to IDLE if `en`==0, otherwise to RUN.
  - `en` is examined only at boundaries. Deassert-then-reassert before a boundary does not stop the divider.
- `cfg_ready` = (state != PEND). Accept = `cfg_valid` & `cfg_ready`.
  - In IDLE: `active_half`<=`cfg_half` at the next edge; state stays IDLE unless `en`. If `en` is also high, RUN starts with the new value.
  - In RUN: value stored in `pend_half`; state becomes PEND.
  - Accept on the same edge as a boundary: the value is not applied at that boundary. It goes to PEND and applies at the next boundary.
- `cfg_half`=0 is legal: divide-by-2, `rise_tick`/`fall_tick` alternate every cycle.
- Width: count is CW bits, never exceeds active_half, no wrap beyond active_half.

## Timing
- Reset values: state IDLE, count 0, `div_clk` 0, `rise_tick` 0, `fall_tick` 0, `active_half` DEF_HALF, `pend_half` 0, `cfg_ready` 1, `busy` 0.
- Reset mid-operation: immediate asynchronous clear to the reset values. Pending ratio discarded.
- `en` sampled high at edge k (in IDLE):
  - `busy`=1 after edge k.
  - `div_clk` rises after edge k+half+1, with `rise_tick` high in that same cycle.
- Ratio accepted in RUN: `cfg_ready` low from the next cycle until the boundary edge. It is 1 again in the cycle after the boundary, when `active_half` shows the new value.
- Stop: after the boundary edge with `en`==0, `div_clk`=0, `fall_tick`=1 for one cycle, `busy`=0.
- All outputs are registered; no combinational path from inputs to outputs except `cfg_ready`, which is a state decode.

## Structure
- Package `clkdiv_pkg`: state enum (IDLE, RUN, PEND), `CW` and `DEF_HALF` defaults.
- Sub-module `clkdiv_core`: counter + toggle flop + tick generation.
  - Inputs: `run`, `half`.
  - Outputs: `div_clk`, `at_boundary`, ticks.
- `clkdiv_ctrl` holds the FSM, the handshake, and `pend_half`.

## Test plan
- Reset, then `en`=1 with DEF_HALF=3:
  - first `rise_tick` 4 cycles after RUN entry.
  - `div_clk` period 8, 50% duty.
  - `active_half`=3.
- In RUN, `cfg_half`=1 accepted mid-low-phase:
  - `cfg_ready`=0 until the next falling boundary.
  - current period stays 8; following periods are 4.
  - `active_half`=1.
- `en` dropped during a high phase:
  - the high phase completes its full half+1 cycles.
  - `fall_tick` pulses once, then IDLE, `busy`=0, `div_clk` stays 0.
- In IDLE, `cfg_half`=0 accepted, then `en`=1: `div_clk` toggles every cycle (period 2).
- Accept coincident with the boundary edge (`cfg_half`=5 from half=3):
  - one more period of 8.
  - then periods of 12.
- Assert `rst` in PEND:
  - all outputs at reset values.
  - `active_half`=3; pending value never applied after release.
